// File: rtl/sargantana_icache_pkg.sv
// Shared defaults, width helper and response record for the Sargantana I-cache hit pipeline.
package sargantana_icache_pkg;

    localparam int unsigned ICACHE_N_WAY   = 4;
    localparam int unsigned ICACHE_TAG_W   = 20;
    localparam int unsigned ICACHE_LINE_W  = 512;
    localparam int unsigned ICACHE_FETCH_W = 128;

    // Index width that never collapses to zero bits for single-entry selections.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned ICACHE_WAY_IDX_W = clog2_min1(ICACHE_N_WAY);

    typedef struct packed {
        logic                          hit;
        logic                          multihit;
        logic [ICACHE_WAY_IDX_W-1:0]   way;
        logic [ICACHE_FETCH_W-1:0]     data;
    } icache_rsp_t;

endpackage

// File: rtl/sargantana_icache_prio_enc.sv
// Lowest-index priority encoder over the per-way hit vector, with any/multiple-hit flags.
module sargantana_icache_prio_enc
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned N_WAY     = ICACHE_N_WAY,
    parameter int unsigned WAY_IDX_W = clog2_min1(N_WAY)
) (
    input  logic [N_WAY-1:0]     vec_i,
    output logic [WAY_IDX_W-1:0] idx_o,
    output logic                 any_o,
    output logic                 multi_o
);

    always_comb begin
        idx_o = '0;
        // Scanning downward lets the lowest set bit win.
        for (int w = int'(N_WAY) - 1; w >= 0; w--) begin
            if (vec_i[w]) begin
                idx_o = WAY_IDX_W'(w);
            end
        end
        any_o   = |vec_i;
        multi_o = ($countones(vec_i) > 1);
    end

endmodule

// File: rtl/sargantana_icache_hit_pipe.sv
// Two-stage elastic I-cache hit check: tag compare and chunk extract, then way select into
// a valid/ready response register, with flush and saturating hit/miss statistics.
module sargantana_icache_hit_pipe
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned N_WAY   = ICACHE_N_WAY,
    parameter int unsigned TAG_W   = ICACHE_TAG_W,
    parameter int unsigned LINE_W  = ICACHE_LINE_W,
    parameter int unsigned FETCH_W = ICACHE_FETCH_W,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned N_CHUNK   = LINE_W / FETCH_W,
    localparam int unsigned IDX_W     = clog2_min1(N_CHUNK),
    localparam int unsigned WAY_IDX_W = clog2_min1(N_WAY)
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      flush_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [TAG_W-1:0]          req_tag_i,
    input  logic [IDX_W-1:0]          req_idx_i,
    input  logic [N_WAY-1:0]          way_valid_i,
    input  logic [N_WAY*TAG_W-1:0]    read_tags_i,
    input  logic [N_WAY*LINE_W-1:0]   data_rd_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic                      rsp_hit_o,
    output logic [WAY_IDX_W-1:0]      rsp_way_o,
    output logic                      rsp_multihit_o,
    output logic [FETCH_W-1:0]        rsp_data_o,
    input  logic                      cnt_clear_i,
    output logic [CNT_W-1:0]          cnt_hit_o,
    output logic [CNT_W-1:0]          cnt_miss_o
);

    typedef struct packed {
        logic                  hit;
        logic                  multihit;
        logic [WAY_IDX_W-1:0]  way;
        logic [FETCH_W-1:0]    data;
    } rsp_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                            rsp_fire;
    logic                            s2_load;
    logic                            s1_adv;
    logic                            req_fire;

    logic [N_WAY-1:0]                hit_vec_p0;
    logic [N_WAY-1:0][FETCH_W-1:0]   chunk_p0;

    logic                            vld_p1_d, vld_p1_q;
    logic [N_WAY-1:0]                hit_vec_p1_d, hit_vec_p1_q;
    logic [N_WAY-1:0][FETCH_W-1:0]   chunk_p1_d, chunk_p1_q;

    logic                            vld_p2_d, vld_p2_q;
    rsp_t                            rsp_p2_d, rsp_p2_q;

    logic [CNT_W-1:0]                cnt_hit_d, cnt_hit_q;
    logic [CNT_W-1:0]                cnt_miss_d, cnt_miss_q;

    logic [WAY_IDX_W-1:0]            sel_way;
    logic                            sel_any;
    logic                            sel_multi;

    // Handshake control: S2 accepts whenever it is empty or draining this cycle.
    assign rsp_fire    = vld_p2_q & rsp_ready_i;
    assign s2_load     = ~vld_p2_q | rsp_fire;
    assign s1_adv      = vld_p1_q & s2_load;
    assign req_ready_o = ~flush_i & (~vld_p1_q | s2_load);
    assign req_fire    = req_valid_i & req_ready_o;

    // ---- stage p0: tag compare and chunk extraction from the raw SRAM read ----
    always_comb begin
        hit_vec_p0 = '0;
        chunk_p0   = '0;
        for (int w = 0; w < int'(N_WAY); w++) begin
            logic [LINE_W-1:0] line;
            line          = data_rd_i[w*LINE_W +: LINE_W];
            hit_vec_p0[w] = way_valid_i[w] & (read_tags_i[w*TAG_W +: TAG_W] == req_tag_i);
            chunk_p0[w]   = FETCH_W'(line >> (int'(req_idx_i) * int'(FETCH_W)));
        end
    end

    // ---- stage p1: captured compare results, waiting for S2 space ----
    always_comb begin
        vld_p1_d     = vld_p1_q;
        hit_vec_p1_d = hit_vec_p1_q;
        chunk_p1_d   = chunk_p1_q;
        if (flush_i) begin
            vld_p1_d = 1'b0;
        end else if (req_fire) begin
            vld_p1_d = 1'b1;
        end else if (s1_adv) begin
            vld_p1_d = 1'b0;
        end
        if (req_fire) begin
            hit_vec_p1_d = hit_vec_p0;
            chunk_p1_d   = chunk_p0;
        end
    end

    sargantana_icache_prio_enc #(
        .N_WAY     (N_WAY),
        .WAY_IDX_W (WAY_IDX_W)
    ) u_prio_enc (
        .vec_i   (hit_vec_p1_q),
        .idx_o   (sel_way),
        .any_o   (sel_any),
        .multi_o (sel_multi)
    );

    // ---- stage p2: selected response held until the consumer takes it ----
    always_comb begin
        vld_p2_d = vld_p2_q;
        rsp_p2_d = rsp_p2_q;
        if (flush_i) begin
            vld_p2_d = 1'b0;
        end else if (s2_load) begin
            vld_p2_d = vld_p1_q;
        end
        if (s1_adv) begin
            rsp_p2_d.hit      = sel_any;
            rsp_p2_d.multihit = sel_multi;
            rsp_p2_d.way      = sel_any ? sel_way : '0;
            rsp_p2_d.data     = sel_any ? chunk_p1_q[sel_way] : '0;
        end
    end

    always_comb begin
        cnt_hit_d  = cnt_hit_q;
        cnt_miss_d = cnt_miss_q;
        if (rsp_fire && rsp_p2_q.hit && (cnt_hit_q != CNT_MAX)) begin
            cnt_hit_d = cnt_hit_q + 1'b1;
        end
        if (rsp_fire && !rsp_p2_q.hit && (cnt_miss_q != CNT_MAX)) begin
            cnt_miss_d = cnt_miss_q + 1'b1;
        end
        if (cnt_clear_i) begin
            cnt_hit_d  = '0;
            cnt_miss_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            rsp_p2_q   <= '0;
            cnt_hit_q  <= '0;
            cnt_miss_q <= '0;
        end else begin
            vld_p1_q   <= vld_p1_d;
            vld_p2_q   <= vld_p2_d;
            rsp_p2_q   <= rsp_p2_d;
            cnt_hit_q  <= cnt_hit_d;
            cnt_miss_q <= cnt_miss_d;
        end
    end

    // S1 payload is only meaningful while vld_p1_q is set, so it needs no reset.
    always_ff @(posedge clk_i) begin
        hit_vec_p1_q <= hit_vec_p1_d;
        chunk_p1_q   <= chunk_p1_d;
    end

    assign rsp_valid_o    = vld_p2_q;
    assign rsp_hit_o      = rsp_p2_q.hit;
    assign rsp_way_o      = rsp_p2_q.way;
    assign rsp_multihit_o = rsp_p2_q.multihit;
    assign rsp_data_o     = rsp_p2_q.data;
    assign cnt_hit_o      = cnt_hit_q;
    assign cnt_miss_o     = cnt_miss_q;

endmodule
